vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Generates 640x480@60Hz VGA timing from the 50 MHz system clock.
//  Produces raw beam counters x/y (sync+porch+active, not active-relative), sync pulses and blanking.
//  Sits directly upstream of Vga_address, which maps x/y (active window x 144..783, y 35..514) to frame-buffer addresses.
//  Also drives the DAC/connector hsync, vsync and blank_b pins.
// PARAMETERS
//  CLK_DIV   2    system clocks per pixel (>=2)
//  H_SYNC    96   hsync pulse width, pixels
//  H_BP      48   horizontal back porch, pixels
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch, pixels
//  V_SYNC    2    vsync pulse width, lines
//  V_BP      33   vertical back porch, lines
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch, lines
//  (H_TOTAL = sum of H_* = 800, V_TOTAL = sum of V_* = 525; both must be <= 1024)
// PORTS
//  clk          in   1   system clock, 50 MHz
//  reset        in   1   synchronous, active-high
//  pix_en       out  1   one-clk strobe; x/y advance on this cycle's rising edge
//  vgaclk       out  1   pixel clock to DAC, period CLK_DIV clks
//  x            out  10  horizontal beam counter, 0..H_TOTAL-1
//  y            out  10  vertical beam counter, 0..V_TOTAL-1
//  hsync        out  1   horizontal sync, active low
//  vsync        out  1   vertical sync, active low
//  blank_b      out  1   1 = inside active window
//  line_start   out  1   one-clk pulse, first clk with x==0
//  frame_start  out  1   one-clk pulse, first clk with x==0 && y==0
// BEHAVIOUR
//  Reset (sync, priority over everything): div=0, x=0, y=0, vgaclk=0, line_start=0, frame_start=0.
//   After reset, decodes give hsync=0, vsync=0, blank_b=0, pix_en=0.
//  Divider: div counts 0..CLK_DIV-1 every clk, wraps to 0.
//   pix_en = (div==CLK_DIV-1), combinational from div.
//   vgaclk registered: 1 when div >= CLK_DIV/2, else 0.
//  Counters update only on clk edges where pix_en=1:
//   x==H_TOTAL-1 -> x=0 and y increments; otherwise x=x+1.
//   y==V_TOTAL-1 at line end -> y=0.
//   With pix_en=0, x and y hold.
//  Decodes are combinational from the registered x/y, so there is zero latency relative to x/y:
//   hsync   = ~(x < H_SYNC)
//   vsync   = ~(y < V_SYNC)
//   blank_b = (x in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE)) && (y in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE))
//  Pulses are registered and high for exactly one clk, on the clk in which x first reads 0 after a wrap:
//   line_start on every wrap of x; frame_start only when y also wraps to 0.
//   No pulse is produced on the reset release itself.
//  First pix_en after reset occurs at the CLK_DIV-th clk; x=1 follows it.
//  Reset asserted mid-frame: all state returns to reset values on the next edge; no partial pulses.
//  Comparisons use 10-bit unsigned arithmetic; no counter ever exceeds TOTAL-1.
// TESTING
//  1. Reset 3 clks, release -> x=0,y=0,hsync=0,blank_b=0; pix_en high on clks 2,4,6...; x=1 after clk 2.
//  2. Run 1600 clks -> x steps 0..799, then x=0,y=1; line_start one clk wide;
//     hsync low exactly for x 0..95 (192 clks).
//  3. Scan full frame -> blank_b first high at (x=144,y=35), last high at (x=783,y=514);
//     count of blank_b-high pix_en cycles = 307200.
//  4. Run 840000 clks after reset -> frame_start single-clk pulse, x=0,y=0;
//     vsync low for y 0..1 (3200 clks).
//  5. Assert reset at x=500,y=200 for 1 clk -> next edge x=0,y=0,div=0;
//     no line_start/frame_start that cycle.
//  6. Override CLK_DIV=4 -> pix_en every 4th clk; vgaclk high 2 / low 2; line period 3200 clks.

Source files
------------

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   640x480@60Hz VGA raster timing from the 50 MHz system clock.
//   A clock divider produces a one-clk pixel strobe (pix_en) and a pixel
//   clock for the DAC (vgaclk). Raw beam counters x/y run over the full
//   line/frame (sync + porches + active) and advance only on pix_en.
//   Sync, blanking and beam counters feed the downstream address mapper,
//   which expects the active window at x 144..783, y 35..514.
//
// Ports
//   clk          in   system clock
//   reset        in   synchronous, active-high; overrides everything
//   pix_en       out  one-clk strobe; x/y advance on this clk's rising edge
//   vgaclk       out  pixel clock to DAC, period CLK_DIV clks
//   x            out  horizontal beam counter, 0..H_TOTAL-1
//   y            out  vertical beam counter, 0..V_TOTAL-1
//   hsync        out  horizontal sync, active low
//   vsync        out  vertical sync, active low
//   blank_b      out  1 = beam inside the active window
//   line_start   out  one-clk pulse on the first clk with x==0 after a wrap
//   frame_start  out  one-clk pulse on the first clk with x==0 && y==0
//                     after a frame wrap
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pix_en,
  output logic       vgaclk,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       blank_b,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_END  = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_END  = 10'(V_SYNC);
  localparam logic [9:0] H_ACT_BEG   = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_ACT_END   = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0] V_ACT_BEG   = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_ACT_END   = 10'(V_SYNC + V_BP + V_ACTIVE);

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_next;
  logic             x_wrap;
  logic             y_wrap;
  logic             h_active;
  logic             v_active;

  always_comb begin
    pix_en   = (div == DIV_LAST);
    div_next = pix_en ? '0 : div + 1'b1;
    x_wrap   = pix_en && (x == H_LAST);
    y_wrap   = x_wrap && (y == V_LAST);
  end

  // vgaclk is registered from the next divider value so that it always
  // equals (div >= CLK_DIV/2) in the same clk, including straight after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      div         <= '0;
      vgaclk      <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div         <= div_next;
      vgaclk      <= (div_next >= DIV_HALF);
      // Pulses land on the clk in which the counters first read the wrapped
      // value; reset release never produces one since x_wrap needs pix_en.
      line_start  <= x_wrap;
      frame_start <= y_wrap;
      if (pix_en) begin
        if (x_wrap) begin
          x <= '0;
          y <= y_wrap ? '0 : y + 10'd1;
        end else begin
          x <= x + 10'd1;
        end
      end
    end
  end

  // Decodes are purely combinational from the registered counters so they
  // line up with x/y with zero latency.
  always_comb begin
    hsync    = ~(x < H_SYNC_END);
    vsync    = ~(y < V_SYNC_END);
    h_active = (x >= H_ACT_BEG) && (x < H_ACT_END);
    v_active = (y >= V_ACT_BEG) && (y < V_ACT_END);
    blank_b  = h_active && v_active;
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  logic clk;
  logic rst_a, rst_b, rst_c;

  logic       a_pix_en, a_vgaclk, a_hsync, a_vsync, a_blank_b, a_line_start, a_frame_start;
  logic [9:0] a_x, a_y;
  logic       b_pix_en, b_vgaclk, b_hsync, b_vsync, b_blank_b, b_line_start, b_frame_start;
  logic [9:0] b_x, b_y;
  logic       c_pix_en, c_vgaclk, c_hsync, c_vsync, c_blank_b, c_line_start, c_frame_start;
  logic [9:0] c_x, c_y;

  int vectors;
  int miscompares;

  // Default 640x480 timing, CLK_DIV=2
  vga_timing_gen u_a (
    .clk(clk), .reset(rst_a), .pix_en(a_pix_en), .vgaclk(a_vgaclk),
    .x(a_x), .y(a_y), .hsync(a_hsync), .vsync(a_vsync), .blank_b(a_blank_b),
    .line_start(a_line_start), .frame_start(a_frame_start)
  );

  // Miniature raster (17 x 11) so whole frames fit in a short run
  vga_timing_gen #(
    .CLK_DIV(2), .H_SYNC(4), .H_BP(3), .H_ACTIVE(8), .H_FP(2),
    .V_SYNC(2), .V_BP(3), .V_ACTIVE(4), .V_FP(2)
  ) u_b (
    .clk(clk), .reset(rst_b), .pix_en(b_pix_en), .vgaclk(b_vgaclk),
    .x(b_x), .y(b_y), .hsync(b_hsync), .vsync(b_vsync), .blank_b(b_blank_b),
    .line_start(b_line_start), .frame_start(b_frame_start)
  );

  // Default timing with CLK_DIV=4
  vga_timing_gen #(.CLK_DIV(4)) u_c (
    .clk(clk), .reset(rst_c), .pix_en(c_pix_en), .vgaclk(c_vgaclk),
    .x(c_x), .y(c_y), .hsync(c_hsync), .vsync(c_vsync), .blank_b(c_blank_b),
    .line_start(c_line_start), .frame_start(c_frame_start)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  int hs_low, ls_cnt, fs_cnt, vs_low, blank_cnt;
  int first_x, first_y, last_x, last_y;
  int bad, pe_cnt, vg_hi, ls_first, ls_second;

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    rst_c = 1'b1;
    step(3);

    // ---- instance A: reset state and first pixel strobes ----
    rst_a = 1'b0;                       // k = 0
    chk("a_rst_x", a_x, 0);
    chk("a_rst_y", a_y, 0);
    chk("a_rst_hsync", a_hsync, 0);
    chk("a_rst_vsync", a_vsync, 0);
    chk("a_rst_blank_b", a_blank_b, 0);
    chk("a_rst_pix_en", a_pix_en, 0);
    chk("a_rst_vgaclk", a_vgaclk, 0);
    chk("a_rst_line_start", a_line_start, 0);
    chk("a_rst_frame_start", a_frame_start, 0);
    step(1);                            // k = 1 (clk 2)
    chk("a_clk2_pix_en", a_pix_en, 1);
    chk("a_clk2_x", a_x, 0);
    chk("a_clk2_vgaclk", a_vgaclk, 1);
    step(1);                            // k = 2
    chk("a_x_after_clk2", a_x, 1);
    chk("a_clk3_pix_en", a_pix_en, 0);
    chk("a_clk3_vgaclk", a_vgaclk, 0);
    step(1597);                         // k = 1599
    chk("a_line0_end_x", a_x, 799);
    chk("a_line0_end_y", a_y, 0);
    chk("a_line0_end_pix_en", a_pix_en, 1);

    // ---- instance A: full line 1 ----
    hs_low = 0;
    ls_cnt = 0;
    for (int k = 1600; k < 3200; k++) begin
      step(1);
      if (!a_hsync) hs_low++;
      if (a_line_start) ls_cnt++;
      if (k == 1600) begin
        chk("a_wrap_x", a_x, 0);
        chk("a_wrap_y", a_y, 1);
        chk("a_wrap_line_start", a_line_start, 1);
      end
      if (k == 1601) begin
        chk("a_line_start_width", a_line_start, 0);
        chk("a_wrap_x_hold", a_x, 0);
      end
      if (k == 1791) chk("a_hsync_x95", a_hsync, 0);
      if (k == 1792) chk("a_hsync_x96", a_hsync, 1);
    end
    chk("a_hsync_low_clks", hs_low, 192);
    chk("a_line_start_count", ls_cnt, 1);
    step(1);                            // k = 3200
    chk("a_line2_x", a_x, 0);
    chk("a_line2_y", a_y, 2);
    chk("a_line2_line_start", a_line_start, 1);

    // ---- instance A: reset mid-line ----
    step(1000);                         // k = 4200
    chk("a_pre_rst_x", a_x, 500);
    chk("a_pre_rst_y", a_y, 2);
    rst_a = 1'b1;
    step(1);
    chk("a_midrst_x", a_x, 0);
    chk("a_midrst_y", a_y, 0);
    chk("a_midrst_pix_en", a_pix_en, 0);
    chk("a_midrst_vgaclk", a_vgaclk, 0);
    chk("a_midrst_line_start", a_line_start, 0);
    chk("a_midrst_frame_start", a_frame_start, 0);
    rst_a = 1'b0;
    step(1);
    chk("a_postrst_pix_en", a_pix_en, 1);
    chk("a_postrst_x", a_x, 0);

    // ---- instance B: whole miniature frame ----
    rst_b = 1'b0;                       // kb = 0
    chk("b_rst_x", b_x, 0);
    chk("b_rst_pix_en", b_pix_en, 0);
    vs_low = (!b_vsync) ? 1 : 0;
    blank_cnt = 0;
    fs_cnt = 0;
    ls_cnt = 0;
    first_x = -1; first_y = -1; last_x = -1; last_y = -1;
    for (int kb = 1; kb < 374; kb++) begin
      step(1);
      if (!b_vsync) vs_low++;
      if (b_pix_en && b_blank_b) begin
        blank_cnt++;
        if (first_x < 0) begin
          first_x = int'(b_x);
          first_y = int'(b_y);
        end
        last_x = int'(b_x);
        last_y = int'(b_y);
      end
      if (b_line_start) ls_cnt++;
      if (b_frame_start) fs_cnt++;
    end
    chk("b_vsync_low_clks", vs_low, 68);
    chk("b_blank_count", blank_cnt, 32);
    chk("b_blank_first_x", first_x, 7);
    chk("b_blank_first_y", first_y, 5);
    chk("b_blank_last_x", last_x, 14);
    chk("b_blank_last_y", last_y, 8);
    chk("b_frame_line_starts", ls_cnt, 10);
    chk("b_no_early_frame_start", fs_cnt, 0);
    step(1);                            // kb = 374
    chk("b_frame_start", b_frame_start, 1);
    chk("b_frame_line_start", b_line_start, 1);
    chk("b_frame_x", b_x, 0);
    chk("b_frame_y", b_y, 0);
    step(1);                            // kb = 375
    chk("b_frame_start_width", b_frame_start, 0);

    // ---- instance B: reset exactly on the frame-wrap strobe ----
    step(372);                          // kb = 747
    chk("b_last_px_x", b_x, 16);
    chk("b_last_px_y", b_y, 10);
    chk("b_last_px_pix_en", b_pix_en, 1);
    rst_b = 1'b1;
    step(1);
    chk("b_rst_wrap_line_start", b_line_start, 0);
    chk("b_rst_wrap_frame_start", b_frame_start, 0);
    chk("b_rst_wrap_x", b_x, 0);
    chk("b_rst_wrap_y", b_y, 0);
    rst_b = 1'b0;
    step(1);
    chk("b_release_line_start", b_line_start, 0);
    chk("b_release_pix_en", b_pix_en, 1);

    // ---- instance C: CLK_DIV = 4 ----
    rst_c = 1'b0;
    bad = 0; pe_cnt = 0; vg_hi = 0; ls_first = -1; ls_second = -1;
    for (int kc = 0; kc <= 6400; kc++) begin
      if (kc > 0) step(1);
      if (a_pix_en !== a_pix_en) bad++;
      if (c_pix_en !== ((kc % 4) == 3)) bad++;
      if (c_vgaclk !== ((kc % 4) >= 2)) bad++;
      if (kc < 3200) begin
        if (c_pix_en) pe_cnt++;
        if (c_vgaclk) vg_hi++;
      end
      if (c_line_start) begin
        if (ls_first < 0) ls_first = kc;
        else if (ls_second < 0) ls_second = kc;
      end
      if (kc == 3200) begin
        chk("c_wrap_x", c_x, 0);
        chk("c_wrap_y", c_y, 1);
      end
    end
    chk("c_phase_errors", bad, 0);
    chk("c_pix_en_per_line", pe_cnt, 800);
    chk("c_vgaclk_high_clks", vg_hi, 1600);
    chk("c_first_line_start", ls_first, 3200);
    chk("c_line_period", ls_second - ls_first, 3200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
